// File: rtl/serial_subn_pkg.sv
// serial_subn_pkg: shared types and helpers for the bit-serial subtractor.
// Holds the controller state encoding and the counter-width helper so the
// top level and any future variants agree on them.
package serial_subn_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one so N=1 still has a counter.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subn_full_sub.sv
// full_sub: combinational one-bit full subtractor cell, x - y - bin.
// The serial datapath reuses this single cell once per clock.
module full_sub
  import serial_subn_pkg::*;
(
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_x ^ i_y ^ i_bin;
  assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

// File: rtl/serial_subn.sv
// serial_subn: bit-serial N-bit subtractor, Diff = A - B - Bin, LSB first.
// A rising edge on Start is registered into a launch flag; the following
// clock loads the operands, then N SHIFT clocks produce one result bit each.
// Done and the results therefore appear N+1 clocks after the trigger edge,
// while Busy is high for exactly the N shifting clocks.
// Optional build macro SERIAL_SUBN_OVF_EN enables the signed overflow flag;
// without it Ovf is tied low and no overflow state exists.
module serial_subn
  import serial_subn_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic         Bin,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         Busy,
  output logic         Done,
  output logic         Ovf
);

  localparam int             CW   = cntWidth(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t         r_state;
  logic           r_startQ;
  logic           r_launch;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_rd;
  logic [N-1:0]   r_diff;
  logic           r_brw;
  logic           r_bout;
  logic           r_busy;
  logic           r_done;
  logic [CW-1:0]  r_cnt;

  logic           w_rise;
  logic           w_d;
  logic           w_bout;
  logic [N-1:0]   w_rdNext;

`ifdef SERIAL_SUBN_OVF_EN
  logic           r_aMsb;
  logic           r_bMsb;
  logic           r_ovf;
`endif

  assign w_rise = Start & ~r_startQ;

  full_sub u_cell (
    .i_x    (r_a[0]),
    .i_y    (r_b[0]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  generate
    if (N == 1) begin : g_narrow
      assign w_rdNext = w_d;
    end else begin : g_wide
      assign w_rdNext = {w_d, r_rd[N-1:1]};
    end
  endgenerate

  // Start edge detector; an edge seen while shifting is dropped, never queued.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_startQ <= 1'b0;
      r_launch <= 1'b0;
    end else begin
      r_startQ <= Start;
      r_launch <= w_rise && (r_state != SHIFT);
    end
  end

  // Controller and serial datapath: load on launch, shift N times, publish results.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_diff  <= '0;
      r_brw   <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_SUBN_OVF_EN
      r_aMsb  <= 1'b0;
      r_bMsb  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (r_launch) begin
            r_a     <= A;
            r_b     <= B;
            r_brw   <= Bin;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SERIAL_SUBN_OVF_EN
            r_aMsb  <= A[N-1];
            r_bMsb  <= B[N-1];
`endif
          end
        end
        SHIFT: begin
          r_brw <= w_bout;
          r_rd  <= w_rdNext;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_diff  <= w_rdNext;
            r_bout  <= w_bout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef SERIAL_SUBN_OVF_EN
            r_ovf   <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign Busy = r_busy;
  assign Done = r_done;
`ifdef SERIAL_SUBN_OVF_EN
  assign Ovf  = r_ovf;
`else
  assign Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subn.sv
// tb_serial_subn: directed scoreboard bench for serial_subn.
// Runs an N=4 instance and an N=1 instance side by side on shared stimulus;
// the N=1 instance sees bit 0 of each operand. Honours SERIAL_SUBN_OVF_EN.
module tb_serial_subn;

  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start  = 1'b0;
  logic       Bin    = 1'b0;
  logic [3:0] A      = 4'd0;
  logic [3:0] B      = 4'd0;

  logic [3:0] diff4;
  logic       bout4, busy4, done4, ovf4;
  logic [0:0] diff1;
  logic       bout1, busy1, done1, ovf1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] d4;
    logic       b4;
    logic       o4;
    logic       d1;
    logic       b1;
    logic       o1;
  } exp_t;

  exp_t sb[$];

  serial_subn #(.N(4)) dut4 (
    .Clock (Clock), .Resetn (Resetn), .Start (Start), .Bin (Bin),
    .A (A), .B (B), .Diff (diff4), .Bout (bout4),
    .Busy (busy4), .Done (done4), .Ovf (ovf4)
  );

  serial_subn #(.N(1)) dut1 (
    .Clock (Clock), .Resetn (Resetn), .Start (Start), .Bin (Bin),
    .A (A[0:0]), .B (B[0:0]), .Diff (diff1), .Bout (bout1),
    .Busy (busy1), .Done (done1), .Ovf (ovf1)
  );

  // Free-running clock, period 10.
  always #5 Clock = ~Clock;

  // Reference result for both widths from plain wide arithmetic.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t       e;
    logic [4:0] r4;
    logic [1:0] r1;
    r4   = {1'b0, a} - {1'b0, b} - {4'd0, bin};
    r1   = {1'b0, a[0]} - {1'b0, b[0]} - {1'b0, bin};
    e.d4 = r4[3:0];
    e.b4 = r4[4];
    e.d1 = r1[0];
    e.b1 = r1[1];
`ifdef SERIAL_SUBN_OVF_EN
    e.o4 = (a[3] != b[3]) && (r4[3] != a[3]);
    e.o1 = (a[0] != b[0]) && (r1[0] != a[0]);
`else
    e.o4 = 1'b0;
    e.o1 = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation with latency/Busy checks; optional Start/operand toggling mid-shift.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit toggle);
    exp_t e;
    int   lat4, lat1, busyCnt;
    logic d1Obs, b1Obs, o1Obs;
    @(negedge Clock);
    A = a; B = b; Bin = bin; Start = 1'b1;
    sb.push_back(model(a, b, bin));
    @(posedge Clock);
    lat4 = -1; lat1 = -1; busyCnt = 0;
    d1Obs = 1'bx; b1Obs = 1'bx; o1Obs = 1'bx;
    for (int i = 1; i <= 20 && lat4 < 0; i++) begin
      @(negedge Clock);
      if (i == 1) Start = 1'b0;
      if (toggle && i == 2) begin
        Start = 1'b1; A = ~a; B = ~b; Bin = ~bin;
      end
      if (toggle && i == 3) Start = 1'b0;
      @(posedge Clock);
      #1;
      if (busy4) busyCnt++;
      if (done1 && lat1 < 0) begin
        lat1 = i; d1Obs = diff1[0]; b1Obs = bout1; o1Obs = ovf1;
      end
      if (done4) lat4 = i;
    end
    e = sb.pop_front();
    $display("[TB] op %0h - %0h - %0b", a, b, bin);
    checkOutput("latency4", lat4, 5);
    checkOutput("latency1", lat1, 2);
    checkOutput("busyCycles4", busyCnt, 4);
    checkOutput("diff4", {28'd0, diff4}, {28'd0, e.d4});
    checkOutput("bout4", {31'd0, bout4}, {31'd0, e.b4});
    checkOutput("ovf4", {31'd0, ovf4}, {31'd0, e.o4});
    checkOutput("diff1", {31'd0, d1Obs}, {31'd0, e.d1});
    checkOutput("bout1", {31'd0, b1Obs}, {31'd0, e.b1});
    checkOutput("ovf1", {31'd0, o1Obs}, {31'd0, e.o1});
  endtask

  // Start held high for many cycles must run exactly one operation.
  task automatic holdStart(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t e;
    int   rises;
    logic prev;
    @(negedge Clock);
    A = a; B = b; Bin = bin; Start = 1'b1;
    sb.push_back(model(a, b, bin));
    prev  = done4;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock);
      #1;
      if (done4 && !prev) rises++;
      prev = done4;
    end
    e = sb.pop_front();
    checkOutput("holdRises", rises, 1);
    checkOutput("holdDone", {31'd0, done4}, 32'd1);
    checkOutput("holdDiff4", {28'd0, diff4}, {28'd0, e.d4});
    checkOutput("holdBout4", {31'd0, bout4}, {31'd0, e.b4});
    checkOutput("holdDiff1", {31'd0, diff1[0]}, {31'd0, e.d1});
    checkOutput("holdBout1", {31'd0, bout1}, {31'd0, e.b1});
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Directed sequence: reset state, arithmetic cases, Start abuse, async reset mid-shift.
  initial begin
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("rstDiff4", {28'd0, diff4}, 32'd0);
    checkOutput("rstDone4", {31'd0, done4}, 32'd0);
    checkOutput("rstBusy4", {31'd0, busy4}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    applyStimulus(4'd7, 4'd3, 1'b0, 1'b0);
    applyStimulus(4'd3, 4'd7, 1'b0, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b1, 1'b0);
    holdStart(4'd6, 4'd1, 1'b0);
    applyStimulus(4'd10, 4'd4, 1'b0, 1'b1);
    applyStimulus(4'd7, 4'hF, 1'b0, 1'b0);
    applyStimulus(4'd5, 4'd2, 1'b0, 1'b0);

    @(negedge Clock);
    A = 4'd9; B = 4'd2; Bin = 1'b0; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("asyncDiff4", {28'd0, diff4}, 32'd0);
    checkOutput("asyncBout4", {31'd0, bout4}, 32'd0);
    checkOutput("asyncBusy4", {31'd0, busy4}, 32'd0);
    checkOutput("asyncDone4", {31'd0, done4}, 32'd0);
    checkOutput("asyncOvf4", {31'd0, ovf4}, 32'd0);
    checkOutput("asyncDone1", {31'd0, done1}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    applyStimulus(4'd9, 4'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
